// File: rtl/tlc5941_rx_model.sv
// Receiving side of a daisy-chained TLC5941 serial interface: shift/latch, PWM generation and readback.
// Define TLC_DC_EN to add the dot-correction latch selected by led_mode=1 on a latch strobe.
module tlc5941_rx_model #(
    parameter int  CHAIN   = 3,
    parameter int  NUM_CH  = 16,
    parameter int  GS_BITS = 12,
    parameter int  DC_BITS = 6,
    localparam int NCH     = CHAIN * NUM_CH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               led_sclk,
    input  logic               led_sin,
    input  logic               led_xlat,
    input  logic               led_blank,
    input  logic               led_gsclk,
    input  logic               led_mode,
    output logic [NCH-1:0]     pwm_out,
    input  logic [5:0]         rd_ch,
    output logic [GS_BITS-1:0] rd_gs,
    output logic [DC_BITS-1:0] rd_dc,
    output logic [9:0]         bit_count,
    output logic [15:0]        frame_count,
    output logic               xlat_pulse,
    output logic               len_err
);

    localparam int                 GS_W   = NCH * GS_BITS;
    localparam logic [9:0]         BC_MAX = 10'd1023;
    localparam logic [9:0]         GS_LEN = 10'(GS_W);
    localparam logic [GS_BITS-1:0] GS_MAX = {GS_BITS{1'b1}};
    localparam logic [6:0]         NCH_7  = 7'(NCH);

    logic                sclk_q, xlat_q, gsclk_q;
    logic                sclk_edge, xlat_edge, gsclk_edge;
    logic [GS_W-1:0]     shreg, shreg_next, gs_lat;
    logic [9:0]          bit_count_next;
    logic [GS_BITS-1:0]  gs_cnt;
    logic [GS_BITS-1:0]  gs_word [NCH];
    logic                rd_in_range;

    assign sclk_edge   = led_sclk  & ~sclk_q;
    assign xlat_edge   = led_xlat  & ~xlat_q;
    assign gsclk_edge  = led_gsclk & ~gsclk_q;
    assign rd_in_range = {1'b0, rd_ch} < NCH_7;

    // Channel k occupies bits [k*GS_BITS +: GS_BITS]; the first word shifted ends up in channel NCH-1.
    for (genvar k = 0; k < NCH; k++) begin : g_gs_word
        assign gs_word[k] = gs_lat[k*GS_BITS +: GS_BITS];
    end

    // The latch must see the register contents after this cycle's shift, so compute it once here.
    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        shreg_next     = shreg;
        bit_count_next = bit_count;
        if (sclk_edge) begin
            shreg_next = {shreg[GS_W-2:0], led_sin};
            if (bit_count != BC_MAX) begin
                bit_count_next = bit_count + 10'd1;
            end
        end
    end

`ifdef TLC_DC_EN
    localparam int         DC_W   = NCH * DC_BITS;
    localparam logic [9:0] DC_LEN = 10'(DC_W);

    logic [DC_W-1:0]    dc_lat;
    logic [DC_BITS-1:0] dc_word [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_dc_word
        assign dc_word[k] = dc_lat[k*DC_BITS +: DC_BITS];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_dc <= '0;
        end else begin
            rd_dc <= rd_in_range ? dc_word[rd_ch] : '0;
        end
    end
`else
    assign rd_dc = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // Edge detectors start high so an input already high at release is not taken as an edge.
            sclk_q      <= 1'b1;
            xlat_q      <= 1'b1;
            gsclk_q     <= 1'b1;
            // NOTE: the wide shift/latch vectors are reset on purpose: a reset must discard partial frames.
            shreg       <= '0;
            gs_lat      <= '0;
            gs_cnt      <= '0;
            bit_count   <= '0;
            frame_count <= '0;
            xlat_pulse  <= 1'b0;
            len_err     <= 1'b0;
            pwm_out     <= '0;
            rd_gs       <= '0;
`ifdef TLC_DC_EN
            dc_lat      <= '0;
`endif
        end else begin
            sclk_q     <= led_sclk;
            xlat_q     <= led_xlat;
            gsclk_q    <= led_gsclk;
            shreg      <= shreg_next;
            bit_count  <= bit_count_next;
            xlat_pulse <= 1'b0;

            if (xlat_edge) begin
                bit_count <= '0;
                if (!led_mode) begin
                    gs_lat      <= shreg_next;
                    len_err     <= len_err | (bit_count_next != GS_LEN);
                    frame_count <= frame_count + 16'd1;
                    xlat_pulse  <= 1'b1;
                end
`ifdef TLC_DC_EN
                else begin
                    dc_lat      <= shreg_next[DC_W-1:0];
                    len_err     <= len_err | (bit_count_next != DC_LEN);
                    frame_count <= frame_count + 16'd1;
                    xlat_pulse  <= 1'b1;
                end
`endif
            end

            // Counter saturates rather than wraps; only blank restarts a PWM cycle.
            if (led_blank) begin
                gs_cnt <= '0;
            end else if (gsclk_edge && gs_cnt != GS_MAX) begin
                gs_cnt <= gs_cnt + 1'b1;
            end

            for (int k = 0; k < NCH; k++) begin
                pwm_out[k] <= !led_blank && (gs_cnt < gs_word[k]);
            end

            rd_gs <= rd_in_range ? gs_word[rd_ch] : '0;
        end
    end

endmodule
